// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered 32-bit ALU between two requesters.
// Grants are round-robin by default; defining ALU_ARB_FIXED_PRIO_EN makes
// requester 0 win every conflict instead. Each accepted request passes through
// an issue register (p1), follows the ALU's output register (p2), and its result
// lands in that requester's response FIFO. Per-requester credits cap the number
// of requests in flight at RSP_DEPTH, so a FIFO can never overflow.
module alu_arbiter #(
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_data_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_data_o,
  output logic [3:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_data_i,
  output logic        busy_o
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  logic [CNT_W-1:0]  credit [2];
  logic [CNT_W-1:0]  count  [2];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [DATA_W-1:0] mem    [2][RSP_DEPTH];
  logic [1:0]        elig, gnt, push, pop, rsp_valid, rsp_ready;
  logic              vld_p1, id_p1, vld_p2, id_p2;
  logic [3:0]        op_p1;
  logic [DATA_W-1:0] a_p1, b_p1;

  // FIFO pointers wrap at RSP_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A requester may be granted only while it holds a free credit.
  always_comb begin
    elig[0] = req0_valid_i && (credit[0] < DEPTH_C);
    elig[1] = req1_valid_i && (credit[1] < DEPTH_C);
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins every conflict; requester 1 only gets idle slots.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      gnt[0] = elig[0];
      gnt[1] = elig[1] && !elig[0];
    end
  end
`else
  logic last;

  // On a conflict the requester not granted most recently wins.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      gnt[0] = elig[0] && (!elig[1] || last);
      gnt[1] = elig[1] && (!elig[0] || !last);
    end
  end

  // Remember who was granted last; starting at 1 lets requester 0 win first.
  always_ff @(posedge clk_i) begin
    if (rst_i) last <= 1'b1;
    else if (gnt[0]) last <= 1'b0;
    else if (gnt[1]) last <= 1'b1;
  end
`endif

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  // p0 -> p1 -> p2: stage valids, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= |gnt;
      vld_p2 <= vld_p1;
    end
  end

  // p0 -> p1: capture the granted request; p1 -> p2: carry its owner id.
  always_ff @(posedge clk_i) begin
    if (|gnt) begin
      id_p1 <= gnt[1];
      op_p1 <= gnt[1] ? req1_op_i : req0_op_i;
      a_p1  <= gnt[1] ? req1_a_i  : req0_a_i;
      b_p1  <= gnt[1] ? req1_b_i  : req0_b_i;
    end
    id_p2 <= id_p1;
  end

  assign alu_op_o = vld_p1 ? op_p1 : '0;
  assign alu_a_o  = vld_p1 ? a_p1  : '0;
  assign alu_b_o  = vld_p1 ? b_p1  : '0;

  // p2: alu_data_i belongs to the request tracked by id_p2.
  assign push      = {vld_p2 && id_p2, vld_p2 && !id_p2};
  assign rsp_valid = {count[1] != '0, count[0] != '0};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign pop       = rsp_valid & rsp_ready;

  // FIFO occupancy, pointers and credits; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 2; n++) begin
        count[n]  <= '0;
        credit[n] <= '0;
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wr_ptr[n] <= ptr_next(wr_ptr[n]);
        if (pop[n])  rd_ptr[n] <= ptr_next(rd_ptr[n]);
        if (push[n] && !pop[n])      count[n] <= count[n] + 1'b1;
        else if (pop[n] && !push[n]) count[n] <= count[n] - 1'b1;
        if (gnt[n] && !pop[n])       credit[n] <= credit[n] + 1'b1;
        else if (pop[n] && !gnt[n])  credit[n] <= credit[n] - 1'b1;
      end
    end
  end

  // Result storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem[n][wr_ptr[n]] <= alu_data_i;
    end
  end

  assign rsp0_valid_o = rsp_valid[0];
  assign rsp1_valid_o = rsp_valid[1];
  assign rsp0_data_o  = rsp_valid[0] ? mem[0][rd_ptr[0]] : '0;
  assign rsp1_data_o  = rsp_valid[1] ? mem[1][rd_ptr[1]] : '0;
  assign busy_o       = vld_p1 || vld_p2 || (|rsp_valid);

  a_no_overflow0: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push[0] && !pop[0] && (count[0] == DEPTH_C)));
  a_no_overflow1: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push[1] && !pop[1] && (count[1] == DEPTH_C)));
endmodule
